// File: rtl/aes_pkg.sv
// Shared AES key-schedule constants: conf encodings, schedule lengths, round
// counts and the key_rev_buf state encoding.
package aes_pkg;

   typedef enum logic [1:0] {
      CONF_128 = 2'd0,
      CONF_192 = 2'd1,
      CONF_256 = 2'd2
   } conf_t;

   localparam logic [6:0] WORDS_128 = 7'd44;
   localparam logic [6:0] WORDS_192 = 7'd52;
   localparam logic [6:0] WORDS_256 = 7'd60;

   localparam logic [3:0] NR_128 = 4'd10;
   localparam logic [3:0] NR_192 = 4'd12;
   localparam logic [3:0] NR_256 = 4'd14;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FULL,
      ST_PLAY
   } state_t;

   // Encoding 3 is reserved and folds onto AES-128.
   function automatic conf_t norm_conf(input logic [1:0] conf);
      case (conf)
         2'd1:    return CONF_192;
         2'd2:    return CONF_256;
         default: return CONF_128;
      endcase
   endfunction

   function automatic logic [6:0] words_of(input conf_t conf);
      case (conf)
         CONF_192: return WORDS_192;
         CONF_256: return WORDS_256;
         default:  return WORDS_128;
      endcase
   endfunction

   function automatic logic [3:0] nr_of(input conf_t conf);
      case (conf)
         CONF_192: return NR_192;
         CONF_256: return NR_256;
         default:  return NR_128;
      endcase
   endfunction

endpackage

// File: rtl/key_rev_addr.sv
// Replay address generator for key_rev_buf: round/word counters, sequence index
// and last-word detect. KEY_REV_BUF_FWD_EN adds a forward-order mode.
module key_rev_addr
   import aes_pkg::*;
(
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       i_load,
   input  logic       i_step,
   input  logic [3:0] i_nr,
`ifdef KEY_REV_BUF_FWD_EN
   input  logic       i_fwd,
`endif
   output logic [5:0] o_addr,
   output logic [5:0] o_seq,
   output logic       o_last
);

   logic [3:0] r_round;
   logic [1:0] r_word;
   logic [5:0] r_seq;
   logic [5:0] w_addr_rev;
   logic       w_last_rev;

   // 4r + j is a plain concatenation since j is exactly two bits.
   assign w_addr_rev = {r_round, r_word};
   assign w_last_rev = (r_round == 4'd0) && (r_word == 2'd3);
   assign o_seq      = r_seq;

`ifdef KEY_REV_BUF_FWD_EN
   logic       r_fwd;
   logic [5:0] r_last_idx;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_fwd      <= 1'b0;
         r_last_idx <= '0;
      end else if (i_load) begin
         r_fwd      <= i_fwd;
         r_last_idx <= {i_nr, 2'b11};
      end
   end

   assign o_addr = r_fwd ? r_seq : w_addr_rev;
   assign o_last = r_fwd ? (r_seq == r_last_idx) : w_last_rev;
`else
   assign o_addr = w_addr_rev;
   assign o_last = w_last_rev;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_round <= '0;
         r_word  <= '0;
         r_seq   <= '0;
      end else if (i_load) begin
         r_round <= i_nr;
         r_word  <= 2'd0;
         r_seq   <= 6'd0;
      end else if (i_step) begin
         r_word <= r_word + 2'd1;
         if (r_word == 2'd3)
            r_round <= r_round - 4'd1;
         r_seq  <= r_seq + 6'd1;
      end
   end

endmodule

// File: rtl/key_rev_buf.sv
// Round-key reversal buffer: captures the forward key schedule and replays it in
// inverse-cipher order. KEY_REV_BUF_FWD_EN adds dir_in for forward replay.
module key_rev_buf
   import aes_pkg::*;
#(
   parameter int DEPTH = 64   // must be >= 60
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        en_in,
   input  logic [1:0]  conf_in,
   input  logic [31:0] key_in,
   input  logic [5:0]  key_num_in,
   input  logic        key_valid_in,
   input  logic        key_last_in,
   input  logic        start_in,
`ifdef KEY_REV_BUF_FWD_EN
   input  logic        dir_in,
`endif
   output logic [31:0] key_out,
   output logic [5:0]  key_num_out,
   output logic        key_valid_out,
   output logic        key_last_out,
   output logic        ready_out,
   output logic        err_out
);

   state_t      r_state;
   conf_t       r_conf;
   logic [31:0] r_mem [DEPTH];

   logic        w_cap0;
   logic        w_wr;
   logic        w_start;
   logic        w_step;
   conf_t       w_conf;
   logic        w_len_ok;
   logic [5:0]  w_addr;
   logic [5:0]  w_seq;
   logic        w_last;

   // A fresh word 0 restarts capture from any state and beats start_in.
   assign w_cap0   = key_valid_in && (key_num_in == 6'd0);
   assign w_wr     = en_in && key_valid_in && (w_cap0 || (r_state == ST_LOAD));
   assign w_start  = en_in && !w_cap0 && start_in && (r_state == ST_FULL);
   assign w_step   = en_in && !w_cap0 && (r_state == ST_PLAY);
   assign w_conf   = w_cap0 ? norm_conf(conf_in) : r_conf;
   assign w_len_ok = ({1'b0, key_num_in} + 7'd1) == words_of(w_conf);

   key_rev_addr u_addr (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .i_load (w_start),
      .i_step (w_step),
      .i_nr   (nr_of(r_conf)),
`ifdef KEY_REV_BUF_FWD_EN
      .i_fwd  (dir_in),
`endif
      .o_addr (w_addr),
      .o_seq  (w_seq),
      .o_last (w_last)
   );

   // NOTE: the register file has no reset; its contents are only ever read after
   // a completed capture has rewritten every replayed address.
   always_ff @(posedge clk_in) begin
      if (w_wr)
         r_mem[key_num_in] <= key_in;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state       <= ST_IDLE;
         r_conf        <= CONF_128;
         key_out       <= '0;
         key_num_out   <= '0;
         key_valid_out <= 1'b0;
         key_last_out  <= 1'b0;
         ready_out     <= 1'b0;
         err_out       <= 1'b0;
      end else if (!en_in) begin
         key_valid_out <= 1'b0;
         key_last_out  <= 1'b0;
      end else begin
         key_valid_out <= 1'b0;
         key_last_out  <= 1'b0;
         if (w_cap0)
            r_conf <= norm_conf(conf_in);

         if (w_wr && key_last_in) begin
            ready_out <= w_len_ok;
            err_out   <= !w_len_ok;
            r_state   <= w_len_ok ? ST_FULL : ST_IDLE;
         end else if (w_cap0) begin
            ready_out <= 1'b0;
            err_out   <= 1'b0;
            r_state   <= ST_LOAD;
         end else begin
            case (r_state)
               ST_FULL: begin
                  if (start_in) begin
                     ready_out <= 1'b0;
                     r_state   <= ST_PLAY;
                  end
               end
               ST_PLAY: begin
                  key_out       <= r_mem[w_addr];
                  key_num_out   <= w_seq;
                  key_valid_out <= 1'b1;
                  key_last_out  <= w_last;
                  if (w_last) begin
                     ready_out <= 1'b1;
                     r_state   <= ST_FULL;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_key_rev_buf.sv
// Self-checking bench for key_rev_buf: an AES key-expansion model builds the
// schedules, a queue of expected replay words is checked on every valid cycle.
module tb_key_rev_buf;

   logic        clk_in       = 1'b0;
   logic        rst_in       = 1'b1;
   logic        en_in        = 1'b1;
   logic [1:0]  conf_in      = 2'd0;
   logic [31:0] key_in       = '0;
   logic [5:0]  key_num_in   = '0;
   logic        key_valid_in = 1'b0;
   logic        key_last_in  = 1'b0;
   logic        start_in     = 1'b0;
`ifdef KEY_REV_BUF_FWD_EN
   logic        dir_in       = 1'b0;
`endif
   logic [31:0] key_out;
   logic [5:0]  key_num_out;
   logic        key_valid_out;
   logic        key_last_out;
   logic        ready_out;
   logic        err_out;

   int total   = 0;
   int bad     = 0;
   int n_valid = 0;

   typedef struct {
      logic [31:0] w;
      logic [5:0]  idx;
      logic        last;
   } exp_t;

   exp_t        exp_q [$];
   logic [7:0]  sbox [256];
   logic [31:0] s128 [64];
   logic [31:0] s256 [64];
   logic [31:0] k128 [4] = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c};
   logic [31:0] k256 [8] = '{32'h603deb10, 32'h15ca71be, 32'h2b73aef0, 32'h857d7781,
                             32'h1f352c07, 32'h3b6108d7, 32'h2d9810a3, 32'h0914dff4};

   key_rev_buf #(.DEPTH(64)) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .en_in         (en_in),
      .conf_in       (conf_in),
      .key_in        (key_in),
      .key_num_in    (key_num_in),
      .key_valid_in  (key_valid_in),
      .key_last_in   (key_last_in),
      .start_in      (start_in),
`ifdef KEY_REV_BUF_FWD_EN
      .dir_in        (dir_in),
`endif
      .key_out       (key_out),
      .key_num_out   (key_num_out),
      .key_valid_out (key_valid_out),
      .key_last_out  (key_last_out),
      .ready_out     (ready_out),
      .err_out       (err_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // ---- AES key expansion model ----
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [7:0] r;
      r = b;
      for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
      return r;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] t);
      return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
   endfunction

   task automatic expand(input bit big);
      logic [31:0] w [64];
      logic [31:0] t;
      logic [7:0]  rcon;
      int nk, nw;
      nk = big ? 8 : 4;
      nw = big ? 60 : 44;
      for (int i = 0; i < 64; i++) w[i] = '0;
      for (int i = 0; i < nk; i++) w[i] = big ? k256[i] : k128[i];
      rcon = 8'h01;
      for (int i = nk; i < nw; i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t    = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
            rcon = gmul(rcon, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int i = 0; i < 64; i++)
         if (big) s256[i] = w[i]; else s128[i] = w[i];
   endtask

   function automatic logic [31:0] sw(input bit big, input int i);
      return big ? s256[i] : s128[i];
   endfunction

   // Inverse-cipher order: round Nr down to 0, words of a round ascending.
   task automatic push_stream(input bit big);
      exp_t e;
      int nr, n;
      nr = big ? 14 : 10;
      n  = 4 * (nr + 1);
      for (int k = 0; k < n; k++) begin
         e.w    = sw(big, 4 * (nr - k / 4) + k % 4);
         e.idx  = 6'(k);
         e.last = (k == n - 1);
         exp_q.push_back(e);
      end
   endtask

   // ---- compare process ----
   always @(negedge clk_in) begin
      exp_t e;
      if (key_valid_out === 1'b1) begin
         n_valid++;
         if (exp_q.size() == 0) begin
            check("valid_with_no_word_expected", key_valid_out, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check("stream_word", key_out, e.w);
            check("stream_idx", key_num_out, e.idx);
            check("stream_last", key_last_out, e.last);
         end
      end
   end

   // ---- stimulus helpers ----
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic load(input bit big, input logic [1:0] conf, input int from, input int upto, input int last_at);
      for (int i = from; i <= upto; i++) begin
         key_valid_in = 1'b1;
         key_num_in   = 6'(i);
         key_in       = sw(big, i);
         key_last_in  = (i == last_at);
         conf_in      = conf;
         tick();
      end
      key_valid_in = 1'b0;
      key_last_in  = 1'b0;
   endtask

   task automatic start_play(input bit big);
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      n_valid  = 0;
      push_stream(big);
   endtask

   task automatic drain(input string name);
      int c;
      c = 0;
      while (exp_q.size() != 0 && c < 200) begin
         @(negedge clk_in);
         c++;
      end
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_key_out"}, key_out, 32'h0);
      check({tag, "_key_num_out"}, key_num_out, 6'h0);
      check({tag, "_key_valid_out"}, key_valid_out, 1'b0);
      check({tag, "_key_last_out"}, key_last_out, 1'b0);
      check({tag, "_ready_out"}, ready_out, 1'b0);
      check({tag, "_err_out"}, err_out, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      build_sbox();
      expand(1'b0);
      expand(1'b1);

      // Reset
      rst_in = 1'b1;
      tick();
      tick();
      rst_in = 1'b0;
      check_reset_outputs("reset");

      // AES-128 capture and replay
      load(1'b0, 2'd0, 0, 20, 43);
      check("ready_during_load", ready_out, 1'b0);
      load(1'b0, 2'd0, 21, 43, 43);
      check("ready_after_128_load", ready_out, 1'b1);
      check("err_after_128_load", err_out, 1'b0);
      start_play(1'b0);
      check("model128_w0", exp_q[0].w, 32'hd014f9a8);
      check("model128_w1", exp_q[1].w, 32'hc9ee2589);
      check("model128_w2", exp_q[2].w, 32'he13f0cc8);
      check("model128_w3", exp_q[3].w, 32'hb6630ca6);
      check("model128_w43", exp_q[43].w, 32'h09cf4f3c);
      check("model128_last43", exp_q[43].last, 1'b1);
      check("no_valid_on_start_edge", key_valid_out, 1'b0);
      tick();
      check("first_word_valid", key_valid_out, 1'b1);
      check("ready_during_play", ready_out, 1'b0);
      drain("drain_128");
      check("valid_count_128", n_valid, 44);
      check("ready_after_replay", ready_out, 1'b1);

      // AES-256 capture, replay twice
      load(1'b1, 2'd2, 0, 59, 59);
      check("ready_after_256_load", ready_out, 1'b1);
      start_play(1'b1);
      check("model256_w0", exp_q[0].w, 32'hfe4890d1);
      check("model256_w1", exp_q[1].w, 32'he6188d0b);
      check("model256_w2", exp_q[2].w, 32'h046df344);
      check("model256_w3", exp_q[3].w, 32'h706c631e);
      drain("drain_256_first");
      check("valid_count_256_first", n_valid, 60);
      start_play(1'b1);
      drain("drain_256_second");
      check("valid_count_256_second", n_valid, 60);

      // Enable pause at replay index 5
      start_play(1'b1);
      repeat (5) tick();
      en_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("pause_valid", key_valid_out, 1'b0);
         check("pause_num_hold", key_num_out, 6'd4);
      end
      en_in = 1'b1;
      tick();
      check("resume_valid", key_valid_out, 1'b1);
      check("resume_num", key_num_out, 6'd5);
      drain("drain_pause");
      check("valid_count_pause", n_valid, 60);

      // Length mismatch: conf=0 with 52 words
      load(1'b1, 2'd0, 0, 51, 51);
      check("err_on_mismatch", err_out, 1'b1);
      check("ready_on_mismatch", ready_out, 1'b0);
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("start_ignored_after_err", key_valid_out, 1'b0);
      end
      check("err_sticky", err_out, 1'b1);

      // Conf 3 behaves as AES-128; word 0 clears the error
      load(1'b0, 2'd3, 0, 0, 43);
      check("err_cleared_by_word0", err_out, 1'b0);
      load(1'b0, 2'd3, 1, 43, 43);
      check("ready_conf3", ready_out, 1'b1);

      // Word 0 and start together in FULL: capture wins
      key_valid_in = 1'b1;
      key_num_in   = 6'd0;
      key_in       = s128[0];
      conf_in      = 2'd3;
      start_in     = 1'b1;
      tick();
      key_valid_in = 1'b0;
      start_in     = 1'b0;
      check("capture_beats_start_ready", ready_out, 1'b0);
      tick();
      check("capture_beats_start_valid", key_valid_out, 1'b0);
      load(1'b0, 2'd3, 1, 43, 43);
      check("ready_after_recapture", ready_out, 1'b1);

      // New word 0 at replay index 20 aborts replay
      start_play(1'b0);
      repeat (20) tick();
      load(1'b1, 2'd2, 0, 0, 59);
      check("abort_remaining_words", exp_q.size(), 24);
      check("abort_valid_drop", key_valid_out, 1'b0);
      exp_q.delete();
      load(1'b1, 2'd2, 1, 59, 59);
      check("ready_after_abort_load", ready_out, 1'b1);
      start_play(1'b1);
      drain("drain_after_abort");
      check("valid_count_after_abort", n_valid, 60);

      // Reset in the middle of a replay
      start_play(1'b1);
      repeat (10) tick();
      rst_in = 1'b1;
      tick();
      exp_q.delete();
      rst_in = 1'b0;
      check_reset_outputs("mid_play_reset");
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("start_ignored_after_reset", key_valid_out, 1'b0);
      end
      check("ready_after_reset", ready_out, 1'b0);
      load(1'b0, 2'd0, 0, 43, 43);
      check("ready_after_reset_load", ready_out, 1'b1);
      start_play(1'b0);
      drain("drain_after_reset");
      check("valid_count_after_reset", n_valid, 44);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
